// File: rtl/psd_div_pkg.sv
// rtl/psd_div_pkg.sv - shared types and constants for the psd divider sequencer
package psd_div_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_STOP = 3'd3,
      S_CAPT = 3'd4,
      S_DONE = 3'd5
   } div_seq_state_t;

   localparam int PSD_DIV_ITERS = 32;
   localparam int PSD_DIV_W     = 32;

   localparam logic [PSD_DIV_W-1:0] PSD_DIVZERO_Q = '1;

endpackage

// File: rtl/psd_div_seq.sv
// rtl/psd_div_seq.sv - operand/result handshake sequencer for the psddivide restoring divider
module psd_div_seq
   import psd_div_pkg::*;
#(
   parameter int ITERS = PSD_DIV_ITERS,
   parameter int W     = PSD_DIV_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_dividend,
   input  logic [W-1:0] in_divisor,
   output logic         div_start,
   output logic         div_stop,
   output logic [W-1:0] div_dividend,
   output logic [W-1:0] div_divisor,
   input  logic [W-1:0] div_quotient,
   input  logic [W-1:0] div_rest,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_quotient,
   output logic [W-1:0] out_rest,
   output logic         out_divzero
);

   // ITERS=1 would give a zero-width counter; keep at least one bit.
   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

   div_seq_state_t r_state;
   logic [CW-1:0]  r_cnt;
   logic           r_div_start;
   logic           r_div_stop;
   logic [W-1:0]   r_div_dividend;
   logic [W-1:0]   r_div_divisor;
   logic           r_out_valid;
   logic [W-1:0]   r_out_quotient;
   logic [W-1:0]   r_out_rest;
   logic           r_out_divzero;

   logic           w_in_ready;
   logic           w_accept;
   logic           w_zero;

   // A finished result may be retired and replaced by a new pair in the same cycle.
   assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
   assign w_accept   = in_valid & w_in_ready;
   assign w_zero     = (in_divisor == '0);

   // Sequencer FSM with registered strobes, operands and result.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_div_start    <= 1'b0;
         r_div_stop     <= 1'b0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_out_valid    <= 1'b0;
         r_out_quotient <= '0;
         r_out_rest     <= '0;
         r_out_divzero  <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses; default them low every cycle.
         r_div_start <= 1'b0;
         r_div_stop  <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_div_dividend <= in_dividend;
                  r_div_divisor  <= in_divisor;
                  if (w_zero) begin
                     // Answered locally: the divider is never started.
                     r_state        <= S_DONE;
                     r_out_valid    <= 1'b1;
                     r_out_quotient <= '1;
                     r_out_rest     <= in_dividend;
                     r_out_divzero  <= 1'b1;
                  end else begin
                     r_state     <= S_LOAD;
                     r_div_start <= 1'b1;
                     r_out_valid <= 1'b0;
                  end
               end else if ((r_state == S_DONE) && out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            S_LOAD: begin
               r_cnt   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (r_cnt == LAST_CNT) begin
                  r_state    <= S_STOP;
                  r_div_stop <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               // The divider registers its result on the edge ending this state.
               r_state <= S_CAPT;
            end
            S_CAPT: begin
               r_out_quotient <= div_quotient;
               r_out_rest     <= div_rest;
               r_out_divzero  <= 1'b0;
               r_out_valid    <= 1'b1;
               r_state        <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = w_in_ready;
   assign div_start    = r_div_start;
   assign div_stop     = r_div_stop;
   assign div_dividend = r_div_dividend;
   assign div_divisor  = r_div_divisor;
   assign out_valid    = r_out_valid;
   assign out_quotient = r_out_quotient;
   assign out_rest     = r_out_rest;
   assign out_divzero  = r_out_divzero;

endmodule

// File: tb/tb_psd_div_seq.sv
// tb/tb_psd_div_seq.sv - self-checking bench for psd_div_seq with a divider stand-in
module tb_psd_div_seq;

   localparam int ITERS = 32;
   localparam int W     = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_dividend = '0;
   logic [W-1:0] in_divisor = '0;
   logic         div_start;
   logic         div_stop;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divisor;
   logic [W-1:0] div_quotient = '0;
   logic [W-1:0] div_rest = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_rest;
   logic         out_divzero;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   psd_div_seq #(.ITERS(ITERS), .W(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_dividend  (in_dividend),
      .in_divisor   (in_divisor),
      .div_start    (div_start),
      .div_stop     (div_stop),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_quotient (div_quotient),
      .div_rest     (div_rest),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_quotient (out_quotient),
      .out_rest     (out_rest),
      .out_divzero  (out_divzero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Divider stand-in: garbage while working, true result registered at the stop edge.
   always @(posedge clock) begin
      if (div_start) begin
         div_quotient <= $urandom;
         div_rest     <= $urandom;
      end else if (div_stop) begin
         div_quotient <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
         div_rest     <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end
   end

   // Reference model: one outstanding operation, timed from its accept cycle.
   bit          m_started = 0;
   bit          m_rst_chk = 0;
   bit          m_pend = 0;
   bit          m_zero = 0;
   int          m_acc = 0;
   logic [31:0] m_q = 0, m_r = 0, m_a = 0, m_b = 0;
   logic        m_dz = 0;
   bit          m_ev, m_rdy, m_st, m_sp;

   // Compare every cycle on the falling edge, then advance the model over the next rising edge.
   always @(negedge clock) begin
      cyc++;
      m_ev  = 0;
      m_rdy = 1;
      if (m_started) begin
         if (m_rst_chk) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_div_start", div_start, 0);
            chk("rst_div_stop", div_stop, 0);
            chk("rst_div_dividend", div_dividend, 0);
            chk("rst_div_divisor", div_divisor, 0);
            chk("rst_out_quotient", out_quotient, 0);
            chk("rst_out_rest", out_rest, 0);
            chk("rst_out_divzero", out_divzero, 0);
            m_rst_chk = 0;
         end else begin
            m_ev  = m_pend && (cyc >= m_acc + (m_zero ? 1 : ITERS + 4));
            m_rdy = !m_pend || (m_ev && out_ready);
            m_st  = m_pend && !m_zero && (cyc == m_acc + 1);
            m_sp  = m_pend && !m_zero && (cyc == m_acc + ITERS + 2);
            chk("out_valid", out_valid, m_ev);
            chk("in_ready", in_ready, m_rdy);
            chk("div_start", div_start, m_st);
            chk("div_stop", div_stop, m_sp);
            chk("div_dividend", div_dividend, m_a);
            chk("div_divisor", div_divisor, m_b);
            if (m_ev) begin
               chk("out_quotient", out_quotient, m_q);
               chk("out_rest", out_rest, m_r);
               chk("out_divzero", out_divzero, m_dz);
            end
         end
      end
      if (reset) begin
         m_started = 1;
         m_rst_chk = 1;
         m_pend    = 0;
         m_a       = 0;
         m_b       = 0;
      end else if (m_started) begin
         if (m_ev && out_ready) m_pend = 0;
         if (in_valid && m_rdy) begin
            m_pend = 1;
            m_acc  = cyc;
            m_a    = in_dividend;
            m_b    = in_divisor;
            m_zero = (in_divisor == 0);
            if (m_zero) begin
               m_q  = 32'hFFFF_FFFF;
               m_r  = in_dividend;
               m_dz = 1;
            end else begin
               m_q  = in_dividend / in_divisor;
               m_r  = in_dividend % in_divisor;
               m_dz = 0;
            end
         end
      end
   end

   // Present a pair and hold it until accepted; returns at #1 after the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, output int waits);
      bit acc;
      bit done;
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      waits = 0;
      done  = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         if (acc) begin
            done = 1;
            break;
         end
         waits++;
      end
      if (!done) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   // Count cycles from the accept edge to out_valid, noting when each strobe appeared.
   task automatic wait_valid(output int lat, output int st, output int sp);
      bit seen;
      lat  = 0;
      st   = -1;
      sp   = -1;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         lat++;
         if (div_start && st < 0) st = lat;
         if (div_stop && sp < 0) sp = lat;
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("valid_timeout", 0, 1);
   endtask

   task automatic pop();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int w, lat, st, sp;
      bit p;
      logic [31:0] a, b;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // 100/7 with exact strobe and result timing.
      send(32'd100, 32'd7, w);
      wait_valid(lat, st, sp);
      chk("lat_100_7", lat, ITERS + 4);
      chk("start_at", st, 1);
      chk("stop_at", sp, ITERS + 2);
      chk("q_100_7", out_quotient, 14);
      chk("r_100_7", out_rest, 2);
      chk("dz_100_7", out_divzero, 0);
      pop();

      send(32'hFFFF_FFFF, 32'd1, w);
      wait_valid(lat, st, sp);
      chk("q_max_1", out_quotient, 32'hFFFF_FFFF);
      chk("r_max_1", out_rest, 0);
      pop();
      send(32'd5, 32'd9, w);
      wait_valid(lat, st, sp);
      chk("q_5_9", out_quotient, 0);
      chk("r_5_9", out_rest, 5);
      pop();

      // Zero divisor answered in one cycle with no strobes.
      send(32'd1234, 32'd0, w);
      wait_valid(lat, st, sp);
      chk("lat_div0", lat, 1);
      chk("start_div0", st, -1);
      chk("stop_div0", sp, -1);
      chk("q_div0", out_quotient, 32'hFFFF_FFFF);
      chk("r_div0", out_rest, 1234);
      chk("dz_div0", out_divzero, 1);
      pop();

      // Backpressure: result held for 10 cycles, then release together with a new pair.
      out_ready = 1'b0;
      send(32'd200, 32'd3, w);
      wait_valid(lat, st, sp);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("hold_q", out_quotient, 66);
         chk("hold_r", out_rest, 2);
         chk("hold_in_ready", in_ready, 0);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(32'd81, 32'd9, w);
      chk("release_accept_waits", w, 0);
      wait_valid(lat, st, sp);
      chk("q_81_9", out_quotient, 9);
      chk("r_81_9", out_rest, 0);
      pop();

      // Reset during the 10th RUN cycle aborts the operation.
      send(32'd1000, 32'd3, w);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      @(posedge clock);
      #1;
      send(32'd50, 32'd5, w);
      wait_valid(lat, st, sp);
      chk("q_50_5", out_quotient, 10);
      chk("r_50_5", out_rest, 0);
      pop();

      // Three back-to-back random ops with out_ready tied high.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send($urandom, $urandom_range(1, 1000), w);
         if (i > 0) chk("b2b_gap", w, ITERS + 3);
      end
      wait_valid(lat, st, sp);
      pop();

      // Random ops with random backpressure and occasional zero divisors.
      for (int n = 0; n < 30; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
         send(a, b, w);
         p = 0;
         for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            p = out_valid && out_ready;
            @(posedge clock);
            #1;
            if (p) break;
            out_ready = ($urandom_range(0, 2) != 0);
         end
         if (!p) chk("rand_drain_timeout", 0, 1);
         out_ready = 1'b1;
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      repeat (3) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
